data_sram_bridge: RTL and testbench
===================================

// Module: data_sram_bridge
// PURPOSE
// Memory-stage bridge between the pipeline's single-cycle data access (address, byte selects, aligned store data) and a
// request/addr_ok/data_ok SRAM-style data bus. Sits directly downstream of the datapath's memory stage and upstream of the data bus.
// Captures one access at a time, holds the pipeline with mem_stall until the bus completes, then returns load data to the stage.
// At most one transaction is outstanding.
// PARAMETERS
// KSEG_MAP   1   1: kseg0/kseg1 addresses (addr[31:29]==3'b100/3'b101) are mapped to physical by clearing addr[31:29]; 0: pass-through
// ADDR_W     32  bus address width; must be 32 when KSEG_MAP=1
// PORTS
// clk          in   1   clock, all state changes on rising edge
// rst          in   1   asynchronous active-high reset
// mem_en       in   1   memory stage holds a valid load/store; must stay stable while mem_stall=1
// mem_wstrb    in   4   store byte enables (selM); 4'b0000 = load
// mem_size     in   2   access size: 0=byte 1=half 2=word
// mem_addr     in   32  virtual byte address (aluoutM)
// mem_wdata    in   32  lane-aligned store data (writedata2M)
// mem_rdata    out  32  load data, valid in DONE; holds last value otherwise
// mem_stall    out  1   pipeline hold request
// bus_req      out  1   bus request
// bus_wr       out  1   1=write, 0=read
// bus_size     out  2   copy of captured mem_size
// bus_addr     out  32  physical address
// bus_wstrb    out  4   byte enables; 0 on reads
// bus_wdata    out  32  store data
// bus_addr_ok  in   1   request accepted this cycle (sampled only while bus_req=1)
// bus_data_ok  in   1   data phase complete (read data valid / write done)
// bus_rdata    in   32  read data, sampled when bus_data_ok=1
// BEHAVIOUR
// - Reset: state=IDLE, bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wstrb=0, bus_wdata=0, mem_rdata=0; mem_stall=0 (mem_en=0).
// - States: IDLE, REQ, WAIT, DONE. bus_* outputs are registered; mem_stall = mem_en && (state != DONE) (combinational).
// - IDLE: mem_en=1 -> capture wr=(mem_wstrb!=0), size, translated addr, wstrb, wdata; bus_req<=1; go REQ. Else stay.
// - REQ: bus_req=1 and all bus_* stable until bus_addr_ok. addr_ok&data_ok same cycle -> latch rdata (read), bus_req<=0, DONE.
//   addr_ok only -> bus_req<=0, WAIT. No addr_ok -> stay.
// - WAIT: bus_data_ok -> latch bus_rdata into mem_rdata (reads only; writes leave mem_rdata unchanged), DONE.
// - DONE: mem_stall=0 for exactly one cycle so the stage advances; unconditionally -> IDLE. mem_en in DONE is the already-served
//   access and is never reissued; a new mem_en is accepted from the following IDLE cycle.
// - Latency: zero-wait bus (addr_ok and data_ok in first REQ cycle) -> stall high 2 cycles, DONE on cycle 3 after mem_en.
// - bus_data_ok in IDLE or REQ-before-addr_ok, and bus_addr_ok while bus_req=0, are ignored (no state change).
// - KSEG_MAP=1: addr[31:29] in {100,101} -> bus_addr = {3'b000, addr[28:0]}; otherwise unchanged. No alignment checks:
//   faulting accesses are suppressed upstream (mem_en=0).
// - mem_en dropping while in REQ/WAIT (flush) is a protocol violation; the bridge completes the bus transaction regardless.
// - Reset mid-transaction: immediate return to IDLE with bus_req=0; any late bus_data_ok after reset is ignored.
// TESTING
// - Zero-wait load: mem_en=1, wstrb=0, addr=0x8000_0010; bus responds addr_ok+data_ok, rdata=0xDEADBEEF in first REQ cycle
//   -> bus_addr=0x0000_0010, bus_wr=0; stall 2 cycles; DONE mem_rdata=0xDEADBEEF.
// - Waited store: wstrb=4'b0011, size=1, wdata=0x0000_1234, addr=0xA000_0102; addr_ok after 3 cycles, data_ok 2 cycles later
//   -> bus_req held 4 cycles with stable fields, bus_wstrb=0011, stall until DONE, mem_rdata unchanged.
// - Back-to-back loads with mem_en held across DONE -> second access issued from the IDLE cycle after DONE; exactly two bus requests.
// - Spurious bus_data_ok in IDLE and in REQ before addr_ok -> no state change, mem_rdata unchanged.
// - rst asserted in WAIT, then data_ok pulse -> bus_req=0, state IDLE, mem_rdata=0, no DONE cycle.
// - KSEG_MAP=0, addr=0x8000_0010 -> bus_addr=0x8000_0010; addr=0x0040_0000 with either setting -> unchanged.

Source files
------------

// File: rtl/data_sram_bridge.sv
// Memory-stage to SRAM-style data bus bridge: captures one pipeline access, stalls the stage
// until the bus completes, then returns load data for one non-stalled DONE cycle.
module data_sram_bridge #(
  parameter bit          KSEG_MAP = 1'b1,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_wstrb,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state;
  logic [31:0] physAddr;

  // kseg0/kseg1 are unmapped windows onto the low 512 MiB of physical space.
  always_comb begin
    physAddr = mem_addr;
    if (KSEG_MAP && (mem_addr[31:29] == 3'b100 || mem_addr[31:29] == 3'b101)) begin
      physAddr = {3'b000, mem_addr[28:0]};
    end
  end

  assign mem_stall = mem_en && (state != StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_addr  <= '0;
      bus_wstrb <= 4'd0;
      bus_wdata <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (mem_en) begin
            bus_req   <= 1'b1;
            bus_wr    <= (mem_wstrb != 4'd0);
            bus_size  <= mem_size;
            bus_addr  <= ADDR_W'(physAddr);
            bus_wstrb <= mem_wstrb;
            bus_wdata <= mem_wdata;
            state     <= StReq;
          end
        end
        StReq: begin
          // Fields stay frozen until the slave accepts the request.
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            if (bus_data_ok) begin
              if (!bus_wr) mem_rdata <= bus_rdata;
              state <= StDone;
            end else begin
              state <= StWait;
            end
          end
        end
        StWait: begin
          if (bus_data_ok) begin
            if (!bus_wr) mem_rdata <= bus_rdata;
            state <= StDone;
          end
        end
        StDone: begin
          // The access still on mem_en here has been served; never reissue it.
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: scheduled bus responder plus a cycle-count
// reference model derived from the access latency rules.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wstrb;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;

  logic [31:0] f_mem_rdata;
  logic        f_mem_stall;
  logic        f_bus_req;
  logic        f_bus_wr;
  logic [1:0]  f_bus_size;
  logic [31:0] f_bus_addr;
  logic [3:0]  f_bus_wstrb;
  logic [31:0] f_bus_wdata;

  int          nChecks = 0;
  int          nFail = 0;
  logic [31:0] modelRdata = 32'd0;
  int          reqEdges = 0;
  logic        prevReq = 1'b0;

  always #5 clk = ~clk;

  data_sram_bridge #(.KSEG_MAP(1'b1), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wstrb(mem_wstrb), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  data_sram_bridge #(.KSEG_MAP(1'b0), .ADDR_W(32)) dutFlat (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wstrb(mem_wstrb), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(f_mem_rdata),
    .mem_stall(f_mem_stall), .bus_req(f_bus_req), .bus_wr(f_bus_wr), .bus_size(f_bus_size),
    .bus_addr(f_bus_addr), .bus_wstrb(f_bus_wstrb), .bus_wdata(f_bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always @(negedge clk) begin
    if (bus_req && !prevReq) reqEdges++;
    prevReq = bus_req;
  end

  // Address model: kseg0 (0x8000_0000..0x9FFF_FFFF) and kseg1 (0xA000_0000..0xBFFF_FFFF)
  // alias the bottom 512 MiB of physical memory.
  function automatic logic [31:0] phys(input logic [31:0] a, input bit mapOn);
    if (mapOn && a >= 32'hA000_0000 && a < 32'hC000_0000) return a - 32'hA000_0000;
    if (mapOn && a >= 32'h8000_0000 && a < 32'hA000_0000) return a - 32'h8000_0000;
    return a;
  endfunction

  // One access: addr_ok after addrWait extra REQ cycles, data_ok dataWait cycles after that.
  // The stage is stalled for 2 + addrWait + dataWait cycles, then sees one DONE cycle.
  task automatic run_access(input logic [3:0] ws, input logic [1:0] sz, input logic [31:0] ad,
                            input logic [31:0] wd, input logic [31:0] rd, input int addrWait,
                            input int dataWait, input bit spur);
    int          last;
    logic [31:0] expAddr;
    logic [31:0] expFlat;
    logic        expStall;
    last    = addrWait + 2 + dataWait;
    expAddr = phys(ad, 1'b1);
    expFlat = phys(ad, 1'b0);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      mem_en      = 1'b1;
      mem_wstrb   = ws;
      mem_size    = sz;
      mem_addr    = ad;
      mem_wdata   = wd;
      bus_rdata   = rd;
      bus_addr_ok = (k == addrWait + 1) ||
                    (spur && (k == 0 || k > addrWait + 1) && $urandom_range(1) == 1);
      bus_data_ok = (k == addrWait + 1 + dataWait) ||
                    (spur && k < addrWait + 1 && $urandom_range(1) == 1);
      #1;
      expStall = (k != last);
      nChecks++;
      if (mem_stall !== expStall) begin
        nFail++;
        $display("FAIL stall k=%0d: got %b want %b", k, mem_stall, expStall);
      end
      if (k >= 1 && k <= addrWait + 1) begin
        nChecks++;
        if (bus_req !== 1'b1 || bus_wr !== (ws != 4'd0) || bus_size !== sz ||
            bus_addr !== expAddr || bus_wstrb !== ws || bus_wdata !== wd) begin
          nFail++;
          $display("FAIL req_fields k=%0d: got req=%b wr=%b sz=%0d addr=%h ws=%b wd=%h want req=1 wr=%b sz=%0d addr=%h ws=%b wd=%h",
                   k, bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
                   (ws != 4'd0), sz, expAddr, ws, wd);
        end
        nChecks++;
        if (f_bus_addr !== expFlat) begin
          nFail++;
          $display("FAIL flat_addr k=%0d: got %h want %h", k, f_bus_addr, expFlat);
        end
      end else begin
        nChecks++;
        if (bus_req !== 1'b0) begin
          nFail++;
          $display("FAIL req_low k=%0d: got %b want 0", k, bus_req);
        end
      end
      if (k == last && ws == 4'd0) modelRdata = rd;
      nChecks++;
      if (mem_rdata !== modelRdata) begin
        nFail++;
        $display("FAIL rdata k=%0d: got %h want %h", k, mem_rdata, modelRdata);
      end
    end
  endtask

  task automatic idle_cycles(input int n, input bit spur);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_en      = 1'b0;
      mem_wstrb   = 4'($urandom);
      mem_addr    = $urandom;
      bus_rdata   = $urandom;
      bus_addr_ok = spur && $urandom_range(1) == 1;
      bus_data_ok = spur && $urandom_range(1) == 1;
      #1;
      nChecks++;
      if (mem_stall !== 1'b0 || bus_req !== 1'b0 || mem_rdata !== modelRdata) begin
        nFail++;
        $display("FAIL idle: got stall=%b req=%b rdata=%h want stall=0 req=0 rdata=%h",
                 mem_stall, bus_req, mem_rdata, modelRdata);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_en = 1'b0; mem_wstrb = 4'd0; mem_size = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    nChecks++;
    if (bus_req !== 1'b0 || bus_wr !== 1'b0 || bus_size !== 2'd0 || bus_addr !== 32'd0 ||
        bus_wstrb !== 4'd0 || bus_wdata !== 32'd0 || mem_rdata !== 32'd0 || mem_stall !== 1'b0) begin
      nFail++;
      $display("FAIL reset_state: got req=%b wr=%b sz=%0d addr=%h ws=%b wd=%h rd=%h stall=%b want all 0",
               bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata, mem_rdata, mem_stall);
    end
    rst = 1'b0;
    modelRdata = 32'd0;
    idle_cycles(1, 1'b0);
  endtask

  task automatic test_zero_wait_load();
    run_access(4'b0000, 2'd2, 32'h8000_0010, 32'h1111_2222, 32'hDEAD_BEEF, 0, 0, 1'b0);
    idle_cycles(1, 1'b0);
  endtask

  task automatic test_waited_store();
    run_access(4'b0011, 2'd1, 32'hA000_0102, 32'h0000_1234, 32'h5555_AAAA, 3, 2, 1'b0);
    idle_cycles(2, 1'b0);
  endtask

  task automatic test_back_to_back();
    reqEdges = 0;
    run_access(4'b0000, 2'd2, 32'h0000_0100, 32'd0, 32'hCAFE_0001, 0, 0, 1'b0);
    run_access(4'b0000, 2'd2, 32'h0000_0104, 32'd0, 32'hCAFE_0002, 1, 1, 1'b0);
    idle_cycles(2, 1'b0);
    nChecks++;
    if (reqEdges !== 2) begin
      nFail++;
      $display("FAIL b2b_req_count: got %0d want 2", reqEdges);
    end
  endtask

  task automatic test_spurious();
    idle_cycles(4, 1'b1);
    run_access(4'b0000, 2'd0, 32'h9000_0003, 32'd0, 32'h0BAD_F00D, 3, 2, 1'b1);
    idle_cycles(2, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_en = 1'b1; mem_wstrb = 4'd0; mem_size = 2'd2; mem_addr = 32'h0000_0200;
      bus_rdata = 32'h7777_7777;
      bus_addr_ok = (k == 1);
      bus_data_ok = 1'b0;
    end
    rst = 1'b1;
    #1;
    modelRdata = 32'd0;
    nChecks++;
    if (bus_req !== 1'b0 || mem_rdata !== 32'd0) begin
      nFail++;
      $display("FAIL reset_mid: got req=%b rdata=%h want req=0 rdata=0", bus_req, mem_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_en = 1'b0;
    bus_data_ok = 1'b1;
    #1;
    nChecks++;
    if (mem_stall !== 1'b0 || bus_req !== 1'b0) begin
      nFail++;
      $display("FAIL reset_late_data: got stall=%b req=%b want 0 0", mem_stall, bus_req);
    end
    idle_cycles(2, 1'b0);
    run_access(4'b1111, 2'd2, 32'h0000_0300, 32'h1234_5678, 32'd0, 0, 1, 1'b0);
    idle_cycles(1, 1'b0);
  endtask

  task automatic test_kseg();
    run_access(4'b0000, 2'd2, 32'h0040_0000, 32'd0, 32'h0040_CAFE, 1, 0, 1'b0);
    run_access(4'b1000, 2'd0, 32'hBFFF_FFFF, 32'hAB00_0000, 32'd0, 0, 0, 1'b0);
    run_access(4'b0000, 2'd2, 32'hC000_0000, 32'd0, 32'h1357_9BDF, 0, 2, 1'b0);
    idle_cycles(1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] ad;
    logic [3:0]  ws;
    for (int i = 0; i < 40; i++) begin
      ad = $urandom;
      if (ad[0]) ad = ad & 32'h3FFF_FFFF | 32'h8000_0000;
      ws = ($urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'd0;
      run_access(ws, 2'($urandom_range(2)), ad, $urandom, $urandom, int'($urandom_range(3)),
                 int'($urandom_range(3)), $urandom_range(1) == 1);
      idle_cycles(int'($urandom_range(2)), $urandom_range(1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_waited_store();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_kseg();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
